// File: rtl/fetch_ctrl_if.sv
// Purpose: bundles clock, reset and every fetch_ctrl control/data signal.
// Ports  : master drives clk/reset and the memory/hazard inputs; slave (the
//          controller) drives the fetch enables, instruction, error and count.
interface fetch_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             clk;
  logic             reset;       // synchronous, active-low
  logic             imem_ready;
  logic [31:0]      inst_F;
  logic             stall_D;
  logic             redirect_D;
  logic             imem_req;
  logic             pc_enab;
  logic             fd_enab;
  logic             fd_flush;
  logic [31:0]      inst_out;
  logic             fetch_err;
  logic [CNT_W-1:0] fetch_cnt;

  modport master (
    output clk, reset, imem_ready, inst_F, stall_D, redirect_D,
    input  imem_req, pc_enab, fd_enab, fd_flush, inst_out, fetch_err, fetch_cnt
  );

  modport slave (
    input  clk, reset, imem_ready, inst_F, stall_D, redirect_D,
    output imem_req, pc_enab, fd_enab, fd_flush, inst_out, fetch_err, fetch_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Purpose: fetch-stage sequencer: PC/F-D enables, F/D flush, imem request,
//          one-entry skid buffer, fetch watchdog and delivered-instruction count.
// Ports  : single ctrl_bus (slave) carrying clk, reset and all fetch signals.
//          Zero added latency; decode stall parks a returned word in the skid
//          buffer and drops the memory request until decode accepts it.
module fetch_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  fetch_ctrl_if.slave ctrl_bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      buf_q, buf_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

  logic             redir;
  logic             imem_req_c, pc_enab_c, fd_enab_c, fd_flush_c;
  logic [31:0]      inst_out_c;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    imem_req_c = 1'b0;
    pc_enab_c  = 1'b0;
    fd_enab_c  = 1'b0;
    fd_flush_c = 1'b0;
    inst_out_c = '0;
    // A redirect seen under stall is ignored; decode re-presents it later.
    redir      = ctrl_bus.redirect_D & ~ctrl_bus.stall_D;

    unique case (state_q)
      ST_RST: begin
        fd_flush_c = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req_c = 1'b1;
        inst_out_c = ctrl_bus.inst_F;
        if (ctrl_bus.imem_ready) begin
          if (redir) begin
            pc_enab_c  = 1'b1;
            fd_flush_c = 1'b1;
          end else if (ctrl_bus.stall_D) begin
            buf_d   = ctrl_bus.inst_F;
            state_d = ST_HOLD;
          end else begin
            pc_enab_c = 1'b1;
            fd_enab_c = 1'b1;
          end
        end else if (redir) begin
          // The in-flight request is orphaned; DROP swallows its response.
          pc_enab_c  = 1'b1;
          fd_flush_c = 1'b1;
          state_d    = ST_DROP;
        end else begin
          fd_flush_c = ~ctrl_bus.stall_D;
        end
      end
      ST_HOLD: begin
        inst_out_c = buf_q;
        if (redir) begin
          pc_enab_c  = 1'b1;
          fd_flush_c = 1'b1;
          buf_d      = '0;
          state_d    = ST_FETCH;
        end else if (!ctrl_bus.stall_D) begin
          pc_enab_c = 1'b1;
          fd_enab_c = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_DROP: begin
        // Decode holds a flushed bubble here, so redirects are meaningless.
        imem_req_c = 1'b1;
        fd_flush_c = ~ctrl_bus.stall_D;
        if (ctrl_bus.imem_ready) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_RST;
    endcase

    // Watchdog: count cycles a request waits for memory, saturating.
    wait_cnt_d = wait_cnt_q;
    if ((state_q == ST_FETCH) || (state_q == ST_DROP)) begin
      if (ctrl_bus.imem_ready) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q != WW'(MAX_WAIT)) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
    fetch_err_d = fetch_err_q | (wait_cnt_d == WW'(MAX_WAIT));
    fetch_cnt_d = fetch_cnt_q + CNT_W'(fd_enab_c);
  end

  always_ff @(posedge ctrl_bus.clk) begin
    if (!ctrl_bus.reset) begin
      state_q     <= ST_RST;
      buf_q       <= '0;
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign ctrl_bus.imem_req  = imem_req_c;
  assign ctrl_bus.pc_enab   = pc_enab_c;
  assign ctrl_bus.fd_enab   = fd_enab_c;
  assign ctrl_bus.fd_flush  = fd_flush_c;
  assign ctrl_bus.inst_out  = inst_out_c;
  assign ctrl_bus.fetch_err = fetch_err_q;
  assign ctrl_bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose: directed self-checking bench for fetch_ctrl with a delivery scoreboard.
// Ports  : none; drives the fetch_ctrl_if instance and the clock.
//          Inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_fetch_ctrl;

  fetch_ctrl_if #(.CNT_W(32)) bus ();
  fetch_ctrl #(.MAX_WAIT(16), .CNT_W(32)) dut (.ctrl_bus(bus));

  // Control vector = {imem_req, pc_enab, fd_enab, fd_flush}
  localparam logic [3:0] C_RST = 4'b0001;
  localparam logic [3:0] C_DLV = 4'b1110;
  localparam logic [3:0] C_BUB = 4'b1001;
  localparam logic [3:0] C_RDR = 4'b1101;
  localparam logic [3:0] C_IDL = 4'b1000;
  localparam logic [3:0] C_HLD = 4'b0000;
  localparam logic [3:0] C_REL = 4'b0110;
  localparam logic [32:0] NO   = 33'd0;

  int          checks   = 0;
  int          failures = 0;
  int unsigned exp_cnt  = 0;
  logic [31:0] sb[$];

  initial bus.clk = 1'b0;
  always #5 bus.clk = ~bus.clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [32:0] xi(input logic [31:0] v);
    return {1'b1, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; push=1 records ins as a word that must reach decode.
  task automatic step(input string tag, input logic rdy, input logic [31:0] ins,
                      input logic stl, input logic rd, input logic push,
                      input logic [3:0] exp, input logic [32:0] exp_inst);
    logic [31:0] e;
    bus.imem_ready = rdy;
    bus.inst_F     = ins;
    bus.stall_D    = stl;
    bus.redirect_D = rd;
    if (push) sb.push_back(ins);
    @(negedge bus.clk);
    chk({tag, ".ctl"}, {60'd0, bus.imem_req, bus.pc_enab, bus.fd_enab, bus.fd_flush},
        {60'd0, exp});
    if (exp_inst[32]) chk({tag, ".inst"}, {32'd0, bus.inst_out}, {32'd0, exp_inst[31:0]});
    if (exp[1]) exp_cnt++;
    if (bus.fd_enab === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s.sb observed=delivery 0x%0h expected=no delivery", tag, bus.inst_out);
      end else begin
        e = sb.pop_front();
        chk({tag, ".data"}, {32'd0, bus.inst_out}, {32'd0, e});
      end
    end
    @(posedge bus.clk);
    #1;
  endtask

  initial begin
    bus.reset      = 1'b0;
    bus.imem_ready = 1'b0;
    bus.inst_F     = '0;
    bus.stall_D    = 1'b0;
    bus.redirect_D = 1'b0;

    // Reset held 3 cycles
    repeat (3) @(posedge bus.clk);
    #1;
    chk("rst.ctl", {60'd0, bus.imem_req, bus.pc_enab, bus.fd_enab, bus.fd_flush}, {60'd0, C_RST});
    chk("rst.inst", {32'd0, bus.inst_out}, 64'd0);
    chk("rst.cnt", {32'd0, bus.fetch_cnt}, 64'd0);
    chk("rst.err", {63'd0, bus.fetch_err}, 64'd0);
    bus.reset = 1'b1;

    // T1: streaming, one per cycle
    step("t1.c0", 1'b1, 32'h1000_0000, 1'b0, 1'b0, 1'b0, C_RST, xi(32'h0));
    for (int i = 0; i < 8; i++)
      step("t1.dlv", 1'b1, 32'h1000_0001 + i, 1'b0, 1'b0, 1'b1, C_DLV, NO);
    chk("t1.cnt", {32'd0, bus.fetch_cnt}, {32'd0, exp_cnt});

    // T2: memory ready every third cycle
    for (int i = 0; i < 3; i++) begin
      step("t2.bub", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, C_BUB, NO);
      step("t2.bub", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, C_BUB, NO);
      step("t2.dlv", 1'b1, 32'h2000_0000 + i, 1'b0, 1'b0, 1'b1, C_DLV, NO);
    end
    chk("t2.err", {63'd0, bus.fetch_err}, 64'd0);
    chk("t2.cnt", {32'd0, bus.fetch_cnt}, {32'd0, exp_cnt});

    // T3: response under stall parks in HOLD
    step("t3.cap", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, C_IDL, xi(32'hDEAD_BEEF));
    for (int i = 0; i < 3; i++)
      step("t3.hold", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, C_HLD, xi(32'hDEAD_BEEF));
    step("t3.rel", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, C_REL, xi(32'hDEAD_BEEF));
    chk("t3.cnt", {32'd0, bus.fetch_cnt}, {32'd0, exp_cnt});

    // T4: redirect while waiting -> DROP, late data discarded
    step("t4.redir", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, C_RDR, NO);
    step("t4.drop", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, C_BUB, NO);
    step("t4.droprd", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, C_BUB, NO);
    step("t4.late", 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, C_BUB, NO);
    step("t4.next", 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, C_DLV, NO);
    chk("t4.cnt", {32'd0, bus.fetch_cnt}, {32'd0, exp_cnt});

    // T5: redirect under stall ignored; taken once stall drops
    step("t5.stl", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, C_IDL, NO);
    step("t5.go", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, C_RDR, NO);
    step("t5.drop", 1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 1'b0, C_BUB, NO);
    step("t5.rdyrd", 1'b1, 32'hBAD0_0002, 1'b0, 1'b1, 1'b0, C_RDR, NO);
    step("t5.next", 1'b1, 32'h5A5A_0002, 1'b0, 1'b0, 1'b1, C_DLV, NO);
    chk("t5.cnt", {32'd0, bus.fetch_cnt}, {32'd0, exp_cnt});

    // T6: watchdog trips after 16 waiting cycles and stays set
    for (int i = 0; i < 20; i++) begin
      chk("t6.err", {63'd0, bus.fetch_err}, {63'd0, (i >= 16)});
      step("t6.wait", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, C_BUB, NO);
    end
    chk("t6.err20", {63'd0, bus.fetch_err}, 64'd1);
    step("t6.dlv", 1'b1, 32'h6000_0001, 1'b0, 1'b0, 1'b1, C_DLV, NO);
    chk("t6.sticky", {63'd0, bus.fetch_err}, 64'd1);
    chk("t6.cnt", {32'd0, bus.fetch_cnt}, {32'd0, exp_cnt});

    // T7: reset while in HOLD drops the buffered word
    step("t7.cap", 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, C_IDL, xi(32'hCAFE_F00D));
    bus.reset = 1'b0;
    repeat (2) @(posedge bus.clk);
    #1;
    exp_cnt = 0;
    chk("t7.rctl", {60'd0, bus.imem_req, bus.pc_enab, bus.fd_enab, bus.fd_flush}, {60'd0, C_RST});
    chk("t7.err", {63'd0, bus.fetch_err}, 64'd0);
    chk("t7.rcnt", {32'd0, bus.fetch_cnt}, 64'd0);
    bus.reset = 1'b1;
    step("t7.c0", 1'b1, 32'h0000_0077, 1'b0, 1'b0, 1'b0, C_RST, xi(32'h0));
    step("t7.dlv", 1'b1, 32'h7700_0001, 1'b0, 1'b0, 1'b1, C_DLV, NO);
    chk("t7.cnt", {32'd0, bus.fetch_cnt}, {32'd0, exp_cnt});
    chk("sb.left", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the fetch stage. It drives the PC register enable, the F/D pipeline register enable and flush, and the instruction-memory request handshake. It is built for an instruction memory with variable latency, a decode-stage stall from the hazard unit, and branch/jump redirects resolved in decode. It sits between the hazard unit, the instruction-memory bus and the fetch datapath, and includes a one-entry skid buffer, a fetch watchdog and a delivered-instruction counter.

Parameters:
MAX_WAIT, 16, wait cycles without imem_ready before fetch_err sets (>=1)
CNT_W, 32, width of fetch_cnt

Ports:
ctrl_bus.clk  input  1  system clock; all state updates on rising edge
ctrl_bus.reset  input  1  reset, synchronous, active-low
imem_ready  input  1  instruction memory returns valid data on inst_F this cycle
inst_F  input  32  instruction word from instruction memory
stall_D  input  1  hazard unit holds decode stage
redirect_D  input  1  branch taken or jump in decode (pc_src_D | jmp)
imem_req  output  1  fetch request; memory latches address on first cycle of a request
pc_enab  output  1  PC register load enable
fd_enab  output  1  F/D register load enable
fd_flush  output  1  F/D register clear (inserts bubble)
inst_out  output  32  instruction presented to F/D register
fetch_err  output  1  sticky watchdog error
fetch_cnt  output  CNT_W  instructions delivered to decode

Behaviour:
- Reset, while ctrl_bus.reset==0 at a clock edge:
  - state=RST, wait_cnt=0, fetch_err=0, fetch_cnt=0, buf=0.
  - Combinational outputs in RST: imem_req=0, pc_enab=0, fd_enab=0, fd_flush=1, inst_out=0.
- Qualified redirect: redir = redirect_D & ~stall_D. redirect_D while stall_D=1 is ignored; decode re-presents it later.
- State RST: the first cycle after reset release flushes F/D, then goes to FETCH.
- State FETCH: imem_req=1, inst_out=inst_F.
  - imem_ready & redir: pc_enab=1 (loads target), fd_flush=1, stay FETCH.
  - imem_ready & ~stall_D & ~redir: pc_enab=1, fd_enab=1, fetch_cnt+1, stay FETCH.
  - imem_ready & stall_D: buf<=inst_F, pc_enab=0, fd_enab=0, go HOLD.
  - ~imem_ready & redir: pc_enab=1, fd_flush=1, go DROP; the outstanding transaction is orphaned.
  - ~imem_ready & ~redir: all enables 0. If stall_D=0, fd_flush=1 (bubble); if stall_D=1, F/D holds.
- State HOLD: imem_req=0, inst_out=buf.
  - stall_D=1: all enables 0.
  - redir: pc_enab=1, fd_flush=1, discard buf, go FETCH.
  - otherwise: pc_enab=1, fd_enab=1, fetch_cnt+1, go FETCH.
- State DROP: imem_req=1, pc_enab=0, fd_enab=0, fd_flush=~stall_D.
  - On imem_ready: data discarded, go FETCH, and a new request issues next cycle at the new PC.
  - redirect_D in DROP is ignored: the decode slot holds a flushed bubble.
- Priority: reset > redir > stall_D > imem_ready. fd_enab and fd_flush are never both 1.
- Watchdog:
  - wait_cnt increments each cycle in FETCH or DROP with imem_ready=0.
  - wait_cnt clears on imem_ready or on entering HOLD; it saturates at MAX_WAIT.
  - fetch_err sets when wait_cnt reaches MAX_WAIT and holds until reset. It does not alter sequencing.
- fetch_cnt wraps modulo 2^CNT_W; it counts only cycles with fd_enab=1.
- Reset mid-request (in FETCH, HOLD or DROP): on the next edge go to RST and drop buf; the late imem_ready is ignored because RST does not sample inputs.
- All outputs except fetch_err, fetch_cnt and the state-derived terms are Mealy combinational. There is no added latency: with imem_ready=1 continuously and no stalls, one instruction is delivered per cycle.

Test Plan:
- Reset held 3 cycles, release; imem_ready=1 constant, no stall -> cycle 0 after release: fd_flush=1, imem_req=0; cycles 1..8: pc_enab=fd_enab=1 each cycle; fetch_cnt=8.
- imem_ready=1 only every 3rd cycle -> 2 bubble cycles (fd_flush=1, pc_enab=0) between deliveries; with MAX_WAIT=16, fetch_err stays 0.
- Memory returns 0xDEADBEEF while stall_D=1 for 4 cycles -> HOLD; inst_out=0xDEADBEEF throughout with imem_req=0; on stall release fd_enab=1 and pc_enab=1 in the same cycle; fetch_cnt+1.
- redirect_D=1 while waiting (imem_ready=0) -> pc_enab=1, fd_flush=1, enter DROP; the next imem_ready (data 0x12345678) is not delivered (fd_enab=0); the following request delivers normally.
- redirect_D=1 with stall_D=1 -> no pc_enab, no flush; deassert stall with redirect_D held -> pc_enab=1, fd_flush=1 that cycle.
- imem_ready held 0 for 20 cycles, MAX_WAIT=16 -> fetch_err=1 at cycle 16 and stays 1 after traffic resumes. Reset asserted in HOLD -> fetch_err=0, fetch_cnt=0, fd_flush=1 after release.
